generic_memory_dp: RTL and testbench

- Parametrised true dual-port successor to the single-port generic SRAM model, used in simulation as instruction/data backing store.
- Two independent ports (A, B) share one array. Each port can read or write, with per-byte write masks.
- Read latency is configurable from 1 to 4 cycles, with a per-port read-valid strobe.
- Cross-port collisions are resolved deterministically.
- Synchronous, active-high reset clears all pipeline state. It does not clear the array.

---
 rtl/generic_memory_pkg.sv | 29 ++
 rtl/generic_memory_rdpipe.sv | 42 ++++
 rtl/generic_memory_dp.sv | 148 ++++++++++++++
 tb/tb_generic_memory_dp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_memory_pkg.sv
// Shared types, limits and byte-mask helpers for the generic dual-port memory.
// Helpers work at MAX_DATA_WIDTH; callers extend/truncate to their own width.
package generic_memory_pkg;

  typedef enum logic {
    WM_READ_OLD      = 1'b0,
    WM_WRITE_THROUGH = 1'b1
  } write_mode_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 512;
  localparam int MAX_BE_WIDTH     = MAX_DATA_WIDTH / 8;
  localparam int COLL_CNT_WIDTH   = 16;

  // Active-low byte enables -> active-high bit mask.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_to_mask(input logic [MAX_BE_WIDTH-1:0] ben);
    logic [MAX_DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BE_WIDTH; i++) m[8*i +: 8] = {8{~ben[i]}};
    return m;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(input logic [MAX_DATA_WIDTH-1:0] old_w,
                                                           input logic [MAX_DATA_WIDTH-1:0] new_w,
                                                           input logic [MAX_DATA_WIDTH-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/generic_memory_rdpipe.sv
// Read-latency delay line of {valid, data}; DEPTH = 0 is a pass-through.
// Data only advances with a valid beat so the tail holds the last read word.
module generic_memory_rdpipe #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld <= '0;
        for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else begin
        vld[0] <= in_valid;
        if (in_valid) dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) dat[i] <= dat[i-1];
        end
      end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
  end

endmodule

// File: rtl/generic_memory_dp.sv
// True dual-port simulation memory with byte masks and 1..4 cycle read latency.
// Define GENERIC_MEM_COLLISION_CHK_EN to add the COLL / COLL_CNT collision monitor.
module generic_memory_dp
  import generic_memory_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  parameter     FILE_NAME    = ""
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN_A,
  input  logic                  WEN_A,
  input  logic [ADDR_WIDTH-1:0] A_A,
  input  logic [DATA_WIDTH-1:0] D_A,
  input  logic [BE_WIDTH-1:0]   BEN_A,
  output logic [DATA_WIDTH-1:0] Q_A,
  output logic                  QVALID_A,
  input  logic                  CEN_B,
  input  logic                  WEN_B,
  input  logic [ADDR_WIDTH-1:0] A_B,
  input  logic [DATA_WIDTH-1:0] D_B,
  input  logic [BE_WIDTH-1:0]   BEN_B,
  output logic [DATA_WIDTH-1:0] Q_B,
  output logic                  QVALID_B
`ifdef GENERIC_MEM_COLLISION_CHK_EN
  ,
  output logic                      COLL,
  output logic [COLL_CNT_WIDTH-1:0] COLL_CNT
`endif
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("generic_memory_dp: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH || BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
    $error("generic_memory_dp: illegal DATA_WIDTH %0d / BE_WIDTH %0d", DATA_WIDTH, BE_WIDTH);
  end

  localparam bit THROUGH = (WRITE_MODE == int'(WM_WRITE_THROUGH));

  function automatic logic [DATA_WIDTH-1:0] mask_of(input logic [BE_WIDTH-1:0] ben);
    logic [MAX_BE_WIDTH-1:0]   ext;
    logic [MAX_DATA_WIDTH-1:0] m;
    ext = '1;
    ext[BE_WIDTH-1:0] = ben;
    m = be_to_mask(ext);
    return m[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] o,
                                                    input logic [DATA_WIDTH-1:0] n,
                                                    input logic [DATA_WIDTH-1:0] m);
    logic [MAX_DATA_WIDTH-1:0] eo, en, em, r;
    eo = '0; en = '0; em = '0;
    eo[DATA_WIDTH-1:0] = o;
    en[DATA_WIDTH-1:0] = n;
    em[DATA_WIDTH-1:0] = m;
    r = merge_bytes(eo, en, em);
    return r[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  wr_a, rd_a, wr_b, rd_b, same_addr;
  logic [DATA_WIDTH-1:0] mask_a, mask_b, wdata_a, wdata_b, rdata_a, rdata_b;

  always_comb begin
    wr_a      = !RST && !CEN_A && !WEN_A;
    rd_a      = !RST && !CEN_A &&  WEN_A;
    wr_b      = !RST && !CEN_B && !WEN_B;
    rd_b      = !RST && !CEN_B &&  WEN_B;
    same_addr = (A_A == A_B);
    mask_a    = mask_of(BEN_A);
    mask_b    = mask_of(BEN_B);
    // On a write/write collision A is layered on top of B, so A wins shared bytes.
    wdata_b   = merge_w(mem[A_B], D_B, mask_b);
    wdata_a   = merge_w((same_addr && wr_b) ? wdata_b : mem[A_A], D_A, mask_a);
    rdata_a   = (THROUGH && same_addr && wr_b) ? wdata_b : mem[A_A];
    rdata_b   = (THROUGH && same_addr && wr_a) ? merge_w(mem[A_B], D_A, mask_a) : mem[A_B];
  end

  // The later assignment takes effect, giving port A priority on a shared address.
  always_ff @(posedge CLK) begin
    if (wr_b) mem[A_B] <= wdata_b;
    if (wr_a) mem[A_A] <= wdata_a;
  end

  always_ff @(posedge CLK) begin
    if (!RST && $isunknown({CEN_A, WEN_A})) $error("generic_memory_dp: X on port A control at %0t", $time);
    if (!RST && $isunknown({CEN_B, WEN_B})) $error("generic_memory_dp: X on port B control at %0t", $time);
  end

  logic                  s0_v_a, s0_v_b;
  logic [DATA_WIDTH-1:0] s0_d_a, s0_d_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_v_a <= 1'b0;
      s0_v_b <= 1'b0;
      s0_d_a <= '0;
      s0_d_b <= '0;
    end else begin
      s0_v_a <= rd_a;
      s0_v_b <= rd_b;
      if (rd_a) s0_d_a <= rdata_a;
      if (rd_b) s0_d_b <= rdata_b;
    end
  end

  generic_memory_rdpipe #(.DEPTH(READ_LATENCY - 1), .WIDTH(DATA_WIDTH)) u_rdpipe_a (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (s0_v_a),
    .in_data  (s0_d_a),
    .out_valid(QVALID_A),
    .out_data (Q_A)
  );

  generic_memory_rdpipe #(.DEPTH(READ_LATENCY - 1), .WIDTH(DATA_WIDTH)) u_rdpipe_b (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (s0_v_b),
    .in_data  (s0_d_b),
    .out_valid(QVALID_B),
    .out_data (Q_B)
  );

`ifdef GENERIC_MEM_COLLISION_CHK_EN
  logic coll_event;
  assign coll_event = !RST && !CEN_A && !CEN_B && same_addr && (wr_a || wr_b);

  always_ff @(posedge CLK) begin
    if (RST) begin
      COLL     <= 1'b0;
      COLL_CNT <= '0;
    end else begin
      COLL <= coll_event;
      if (coll_event && COLL_CNT != '1) COLL_CNT <= COLL_CNT + 1'b1;
      if (coll_event) $warning("generic_memory_dp: collision at addr %h time %0t", A_A, $time);
    end
  end
`endif

endmodule

// File: tb/tb_generic_memory_dp.sv
// Bench for generic_memory_dp: four instances (latency 1..4, alternating write mode)
// driven in lockstep and compared every cycle against a cycle-scheduled reference model.
module tb_generic_memory_dp;

  localparam int NDUT = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cen_a, wen_a, cen_b, wen_b;
  logic [AW-1:0] a_a, a_b;
  logic [DW-1:0] d_a, d_b;
  logic [BW-1:0] ben_a, ben_b;

  logic [DW-1:0] q_a [NDUT];
  logic [DW-1:0] q_b [NDUT];
  logic          qv_a [NDUT];
  logic          qv_b [NDUT];
`ifdef GENERIC_MEM_COLLISION_CHK_EN
  logic          coll [NDUT];
  logic [15:0]   coll_cnt [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    generic_memory_dp #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .READ_LATENCY(g + 1),
      .WRITE_MODE  (g % 2)
    ) u_dut (
      .CLK     (clk),
      .RST     (rst),
      .CEN_A   (cen_a),
      .WEN_A   (wen_a),
      .A_A     (a_a),
      .D_A     (d_a),
      .BEN_A   (ben_a),
      .Q_A     (q_a[g]),
      .QVALID_A(qv_a[g]),
      .CEN_B   (cen_b),
      .WEN_B   (wen_b),
      .A_B     (a_b),
      .D_B     (d_b),
      .BEN_B   (ben_b),
      .Q_B     (q_b[g]),
      .QVALID_B(qv_b[g])
`ifdef GENERIC_MEM_COLLISION_CHK_EN
      ,
      .COLL    (coll[g]),
      .COLL_CNT(coll_cnt[g])
`endif
    );
  end

  // Reference model: word array plus per-cycle expected completions.
  logic [DW-1:0] mem_m [2**AW];
  bit            exp_v [NDUT][2][MAXC];
  logic [DW-1:0] exp_d [NDUT][2][MAXC];
  logic [DW-1:0] last_q [NDUT][2];
  bit            exp_coll [MAXC];
  int            coll_model;
  int            cyc, checks, errors;
  int            pulse_b [NDUT];
  int            first_b [NDUT];
  int            pulse_a [NDUT];
  int            coll_seen [NDUT];

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                        input logic [BW-1:0] ben);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (!ben[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input int d, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    cen_a = 1'b1; wen_a = 1'b1; a_a = '0; d_a = '0; ben_a = '0;
    cen_b = 1'b1; wen_b = 1'b1; a_b = '0; d_b = '0; ben_b = '0;
  endtask

  task automatic op_a(input logic wr, input int addr, input logic [DW-1:0] data, input logic [BW-1:0] ben);
    cen_a = 1'b0; wen_a = !wr; a_a = AW'(addr); d_a = data; ben_a = ben;
  endtask

  task automatic op_b(input logic wr, input int addr, input logic [DW-1:0] data, input logic [BW-1:0] ben);
    cen_b = 1'b0; wen_b = !wr; a_b = AW'(addr); d_b = data; ben_b = ben;
  endtask

  task automatic tick();
    logic [DW-1:0] old_v, thr_v;
    bit ok_a, ok_b, ev;
    ok_a = !cen_a;
    ok_b = !cen_b;
    ev   = 1'b0;
    if (rst) begin
      for (int d = 0; d < NDUT; d++)
        for (int p = 0; p < 2; p++)
          for (int c = cyc; c < cyc + 4; c++) exp_v[d][p][c] = 1'b0;
      coll_model = 0;
    end else begin
      if (ok_a && wen_a) begin
        old_v = mem_m[a_a];
        thr_v = (ok_b && !wen_b && a_a == a_b) ? mrg(old_v, d_b, ben_b) : old_v;
        for (int d = 0; d < NDUT; d++) begin
          exp_v[d][0][cyc + d] = 1'b1;
          exp_d[d][0][cyc + d] = (d % 2 == 1) ? thr_v : old_v;
        end
      end
      if (ok_b && wen_b) begin
        old_v = mem_m[a_b];
        thr_v = (ok_a && !wen_a && a_a == a_b) ? mrg(old_v, d_a, ben_a) : old_v;
        for (int d = 0; d < NDUT; d++) begin
          exp_v[d][1][cyc + d] = 1'b1;
          exp_d[d][1][cyc + d] = (d % 2 == 1) ? thr_v : old_v;
        end
      end
      ev = ok_a && ok_b && (a_a == a_b) && (!wen_a || !wen_b);
      if (ev && coll_model < 65535) coll_model++;
      if (ok_b && !wen_b) mem_m[a_b] = mrg(mem_m[a_b], d_b, ben_b);
      if (ok_a && !wen_a) mem_m[a_a] = mrg(mem_m[a_a], d_a, ben_a);
    end
    exp_coll[cyc] = ev;

    @(posedge clk);
    #1;

    for (int d = 0; d < NDUT; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rst) last_q[d][p] = '0;
        else if (exp_v[d][p][cyc]) last_q[d][p] = exp_d[d][p][cyc];
      end
      chk("qvalid_a", d, DW'(qv_a[d]), DW'(exp_v[d][0][cyc]));
      chk("q_a",      d, q_a[d], last_q[d][0]);
      chk("qvalid_b", d, DW'(qv_b[d]), DW'(exp_v[d][1][cyc]));
      chk("q_b",      d, q_b[d], last_q[d][1]);
      if (qv_b[d]) begin
        if (pulse_b[d] == 0) first_b[d] = cyc;
        pulse_b[d]++;
      end
      if (qv_a[d]) pulse_a[d]++;
`ifdef GENERIC_MEM_COLLISION_CHK_EN
      chk("coll",     d, DW'(coll[d]), DW'(exp_coll[cyc]));
      chk("coll_cnt", d, DW'(coll_cnt[d]), DW'(coll_model));
      if (coll[d]) coll_seen[d]++;
`endif
    end
    cyc++;
  endtask

  task automatic flush(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0;
    checks = 0; errors = 0; cyc = 0; coll_model = 0;
    for (int d = 0; d < NDUT; d++) begin
      last_q[d][0] = '0; last_q[d][1] = '0;
      pulse_b[d] = 0; first_b[d] = -1; pulse_a[d] = 0; coll_seen[d] = 0;
    end
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      idle();
      op_a(1'b1, i, $urandom, 4'b0000);
      tick();
    end

    // Reset clears outputs but not the array; writes during reset are dropped.
    idle(); op_a(1'b1, 5, 32'hDEADBEEF, 4'b0000); tick();
    rst = 1'b1;
    idle(); op_a(1'b0, 5, '0, '0); op_b(1'b1, 5, 32'h0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < NDUT; d++) chk("rst_q_a_zero", d, q_a[d], 32'h0);
    end
    rst = 1'b0;
    idle(); op_a(1'b0, 5, '0, '0); tick();
    flush(5);
    for (int d = 0; d < NDUT; d++) chk("rst_readback", d, q_a[d], 32'hDEADBEEF);

    // Byte-masked write.
    idle(); op_a(1'b1, 16, 32'hAABBCCDD, 4'b0000); tick();
    idle(); op_a(1'b1, 16, 32'h11223344, 4'b1010); tick();
    idle(); op_b(1'b0, 16, '0, '0); tick();
    flush(5);
    for (int d = 0; d < NDUT; d++) chk("byte_mask", d, q_b[d], 32'hAA22CC44);

    // Back-to-back burst on B.
    for (int d = 0; d < NDUT; d++) begin pulse_b[d] = 0; first_b[d] = -1; end
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin idle(); op_b(1'b0, i, '0, '0); tick(); end
    flush(6);
    for (int d = 0; d < NDUT; d++) begin
      chk("burst_count", d, DW'(pulse_b[d]), 32'd8);
      chk("burst_first", d, DW'(first_b[d]), DW'(c0 + d));
    end

    // Write/write collision: port A wins shared bytes.
    idle(); op_a(1'b1, 3, 32'h000000FF, 4'b0000); op_b(1'b1, 3, 32'hFFFF0000, 4'b1100); tick();
    idle(); op_b(1'b0, 3, '0, '0); tick();
    flush(5);
    for (int d = 0; d < NDUT; d++) chk("ww_collision", d, q_b[d], 32'h000000FF);

    // Read-during-write from the other port.
    idle(); op_a(1'b1, 7, 32'h12345678, 4'b0000); tick();
    idle(); op_a(1'b1, 7, 32'hCAFEF00D, 4'b0000); op_b(1'b0, 7, '0, '0); tick();
    flush(5);
    for (int d = 0; d < NDUT; d++)
      chk("rdw", d, q_b[d], (d % 2 == 1) ? 32'hCAFEF00D : 32'h12345678);

    // Reset right after a read: nothing may complete afterwards.
    idle(); op_a(1'b0, 5, '0, '0); tick();
    for (int d = 0; d < NDUT; d++) pulse_a[d] = 0;
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    flush(6);
    for (int d = 0; d < NDUT; d++) chk("midflight_drop", d, DW'(pulse_a[d]), 32'd0);

`ifdef GENERIC_MEM_COLLISION_CHK_EN
    for (int d = 0; d < NDUT; d++) coll_seen[d] = 0;
    idle(); op_a(1'b1, 9, 32'h01010101, 4'b0000); op_b(1'b1, 9, 32'h02020202, 4'b0011); tick();
    flush(1);
    idle(); op_a(1'b0, 9, '0, '0); op_b(1'b1, 9, 32'h03030303, 4'b0000); tick();
    flush(2);
    for (int d = 0; d < NDUT; d++) begin
      chk("coll_pulses", d, DW'(coll_seen[d]), 32'd2);
      chk("coll_cnt_final", d, DW'(coll_cnt[d]), 32'd2);
    end
`endif

    // Random traffic on a small address window, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0)
        op_a($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom, 4'($urandom));
      if ($urandom_range(0, 3) != 0)
        op_b($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom, 4'($urandom));
      tick();
    end
    rst = 1'b0;
    flush(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
